// File: rtl/axis_burst_packer_if.sv
// -----------------------------------------------------------------------------
// axis_burst_packer_if
// Purpose : AXI4-Stream bundle used on both sides of axis_burst_packer.
// Signals : tdata  - payload word
//           tvalid - source has a word
//           tready - sink accepts the word
//           tlast  - final word of a packet (ignored on the packer's input)
// Modports: master drives tdata/tvalid/tlast, slave drives tready.
// -----------------------------------------------------------------------------
interface axis_burst_packer_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_burst_packer.sv
// -----------------------------------------------------------------------------
// axis_burst_packer
// Purpose : Sits behind a first-word-fall-through FIFO. Waits until the FIFO
//           holds a full programmed burst, then moves exactly that many words
//           to m_axis as one gap-free packet with tlast on the final word.
// Ports   : aclk       - clock, rising edge
//           areset     - synchronous active-high reset
//           cfg_data   - burst length in words, 0 disables the packer
//           fifo_count - upstream FIFO read count
//           sts_data   - number of completed bursts (wraps)
//           s_axis     - slave stream from the FIFO (tlast unused)
//           m_axis     - registered master stream towards the DMA writer
// Options : define AXIS_BURST_TIMEOUT_EN to flush a partial FIFO as a short
//           packet after TIMEOUT_CYCLES idle cycles.
// -----------------------------------------------------------------------------
module axis_burst_packer #(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int CNTR_WIDTH       = 16,
   parameter int TIMEOUT_CYCLES   = 1024
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [CNTR_WIDTH-1:0] cfg_data,
   input  logic [CNTR_WIDTH-1:0] fifo_count,
   output logic [31:0]           sts_data,
   axis_burst_packer_if.slave    s_axis,
   axis_burst_packer_if.master   m_axis
);

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [CNTR_WIDTH-1:0] word_cnt;
   logic [CNTR_WIDTH-1:0] burst_len;
   logic                  take;
   logic                  last_word;
   logic                  last_sent;
   logic                  start_full;
   logic                  start_timeout;

   assign take       = s_axis.tvalid & s_axis.tready;
   assign last_word  = (word_cnt == burst_len - 1'b1);
   assign last_sent  = m_axis.tvalid & m_axis.tready & m_axis.tlast;
   assign start_full = (cfg_data != '0) && (fifo_count >= cfg_data);

`ifdef AXIS_BURST_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [IDLE_W-1:0] idle_cnt;
   logic              partial;

   // A partial FIFO is one that holds something but not yet a full burst.
   assign partial       = (fifo_count != '0) && (fifo_count < cfg_data);
   assign start_timeout = (state == IDLE) && partial &&
                          (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge aclk) begin
      if (areset || state != IDLE || !partial || start_timeout)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + 1'b1;
   end
`else
   assign start_timeout = 1'b0;
`endif

   // State register
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge aclk) begin
      if (areset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   // NOTE: the default assignment at the top keeps this block free of inferred latches.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start_full || start_timeout) state_nxt = BURST;
         BURST:   if (take && last_word)           state_nxt = DRAIN;
         DRAIN:   if (last_sent)                   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: read strobe only in BURST and only when the output
   // register is empty or being emptied this cycle. Held low under reset so
   // the FIFO never sees a read while the packer is being cleared.
   always_comb begin
      s_axis.tready = 1'b0;
      if (state == BURST && !areset)
         s_axis.tready = ~m_axis.tvalid | m_axis.tready;
   end

   // Datapath: burst length latch, word counter, output register, status.
   // NOTE: every flop here is a control or output register, so all of them get a reset value.
   always_ff @(posedge aclk) begin
      if (areset) begin
         burst_len     <= '0;
         word_cnt      <= '0;
         sts_data      <= '0;
         m_axis.tdata  <= '0;
         m_axis.tvalid <= 1'b0;
         m_axis.tlast  <= 1'b0;
      end else begin
         // Length is captured only when leaving IDLE, so cfg_data edits
         // during a burst are ignored until the next IDLE evaluation.
         if (state == IDLE) begin
            if (start_full) begin
               burst_len <= cfg_data;
               word_cnt  <= '0;
            end else if (start_timeout) begin
               burst_len <= fifo_count;
               word_cnt  <= '0;
            end
         end

         if (take) begin
            word_cnt      <= word_cnt + 1'b1;
            m_axis.tdata  <= s_axis.tdata;
            m_axis.tvalid <= 1'b1;
            m_axis.tlast  <= last_word;
         end else if (m_axis.tready) begin
            m_axis.tvalid <= 1'b0;
         end

         if (state == DRAIN && last_sent)
            sts_data <= sts_data + 32'd1;
      end
   end

endmodule

// File: tb/tb_axis_burst_packer.sv
// -----------------------------------------------------------------------------
// tb_axis_burst_packer
// Purpose : Self-checking bench for axis_burst_packer. A queue models the
//           first-word-fall-through FIFO in front of the packer; every word
//           accepted on m_axis is logged and compared against hand-derived
//           expectations (table rows plus directed corner-case sequences).
// -----------------------------------------------------------------------------
module tb_axis_burst_packer;

   typedef struct {
      logic [15:0] cfg;
      int          words;
      bit          toggle;
      int          exp_beats;
      int          exp_sts;
      int          exp_remain;
   } row_t;

   typedef struct {
      logic [31:0] data;
      logic        last;
      int          cyc;
   } beat_t;

   logic        clk;
   logic        areset;
   logic [15:0] cfg_data;
   logic [15:0] fifo_count;
   logic [31:0] sts_data;

   axis_burst_packer_if #(.DATA_WIDTH(32)) s_if ();
   axis_burst_packer_if #(.DATA_WIDTH(32)) m_if ();

   axis_burst_packer #(
      .AXIS_TDATA_WIDTH(32),
      .CNTR_WIDTH      (16),
      .TIMEOUT_CYCLES  (16)
   ) dut (
      .aclk      (clk),
      .areset    (areset),
      .cfg_data  (cfg_data),
      .fifo_count(fifo_count),
      .sts_data  (sts_data),
      .s_axis    (s_if),
      .m_axis    (m_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks;
   int          n_pass;
   int          cyc;
   bit          tready_toggle;
   logic [31:0] fifo_q[$];
   beat_t       beats[$];
   logic        stall_prev;
   logic [31:0] stall_data;
   logic        stall_last;
   logic        rst_edge;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic drive_fifo();
      s_if.tvalid = (fifo_q.size() > 0);
      s_if.tdata  = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
      fifo_count  = 16'(fifo_q.size());
   endtask

   // One clock: sample handshakes on the falling edge, update the FIFO model
   // and m_axis.tready just after the rising edge.
   task automatic tick();
      logic s_take;
      @(negedge clk);
      if (stall_prev && !rst_edge) begin
         check("hold_valid", 64'(m_if.tvalid), 64'd1);
         check("hold_data",  64'(m_if.tdata),  64'(stall_data));
         check("hold_last",  64'(m_if.tlast),  64'(stall_last));
      end
      stall_prev = (m_if.tvalid === 1'b1) && (m_if.tready === 1'b0);
      stall_data = m_if.tdata;
      stall_last = m_if.tlast;
      s_take     = (s_if.tvalid === 1'b1) && (s_if.tready === 1'b1);
      if ((m_if.tvalid === 1'b1) && (m_if.tready === 1'b1))
         beats.push_back('{data: m_if.tdata, last: m_if.tlast, cyc: cyc});
      @(posedge clk);
      rst_edge = areset;
      cyc++;
      #1;
      if (s_take && fifo_q.size() > 0)
         void'(fifo_q.pop_front());
      m_if.tready = tready_toggle ? ~m_if.tready : 1'b1;
      drive_fifo();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      areset        = 1'b1;
      cfg_data      = '0;
      tready_toggle = 1'b0;
      m_if.tready   = 1'b1;
      fifo_q.delete();
      drive_fifo();
      run(2);
      areset     = 1'b0;
      beats.delete();
      stall_prev = 1'b0;
      rst_edge   = 1'b0;
   endtask

   task automatic preload(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) fifo_q.push_back(base + 32'(i));
      drive_fifo();
   endtask

   task automatic wait_beats(input string name, input int n);
      for (int k = 0; k < 50 && beats.size() < n; k++) tick();
      check(name, 64'(beats.size() >= n), 64'd1);
   endtask

   int lasts;

   initial begin
      row_t rows[6];
      logic [31:0] base;

      rows[0] = '{cfg: 16'd4, words: 10, toggle: 1'b0, exp_beats: 8, exp_sts: 2, exp_remain: 2};
      rows[1] = '{cfg: 16'd8, words: 8,  toggle: 1'b1, exp_beats: 8, exp_sts: 1, exp_remain: 0};
      rows[2] = '{cfg: 16'd1, words: 3,  toggle: 1'b0, exp_beats: 3, exp_sts: 3, exp_remain: 0};
      rows[3] = '{cfg: 16'd0, words: 5,  toggle: 1'b0, exp_beats: 0, exp_sts: 0, exp_remain: 5};
      rows[4] = '{cfg: 16'd3, words: 7,  toggle: 1'b1, exp_beats: 6, exp_sts: 2, exp_remain: 1};
      rows[5] = '{cfg: 16'd2, words: 5,  toggle: 1'b1, exp_beats: 4, exp_sts: 2, exp_remain: 1};

      n_checks      = 0;
      n_pass        = 0;
      cyc           = 0;
      stall_prev    = 1'b0;
      rst_edge      = 1'b1;
      tready_toggle = 1'b0;

      // Reset held with an eager FIFO in front: everything must stay quiet.
      areset      = 1'b1;
      cfg_data    = 16'd4;
      fifo_count  = 16'd100;
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'hDEAD_BEEF;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
         check("rst_m_tlast",  64'(m_if.tlast),  64'd0);
         check("rst_m_tdata",  64'(m_if.tdata),  64'd0);
         check("rst_sts",      64'(sts_data),    64'd0);
         check("rst_s_tready", 64'(s_if.tready), 64'd0);
      end

      // Table-driven bursts: words are base+i, tlast every cfg words.
      for (int r = 0; r < 6; r++) begin
         do_reset();
         base          = 32'h1000 * 32'(r + 1);
         cfg_data      = rows[r].cfg;
         tready_toggle = rows[r].toggle;
         preload(rows[r].words, base);
         run(60);
         check($sformatf("row%0d_beats", r),  64'(beats.size()),  64'(rows[r].exp_beats));
         check($sformatf("row%0d_sts", r),    64'(sts_data),      64'(rows[r].exp_sts));
         check($sformatf("row%0d_remain", r), 64'(fifo_q.size()), 64'(rows[r].exp_remain));
         for (int i = 0; i < beats.size() && i < rows[r].exp_beats; i++) begin
            check($sformatf("row%0d_data%0d", r, i), 64'(beats[i].data), 64'(base + 32'(i)));
            check($sformatf("row%0d_last%0d", r, i), 64'(beats[i].last),
                  64'(((i + 1) % int'(rows[r].cfg)) == 0));
            if (!rows[r].toggle && i > 0 && (i % int'(rows[r].cfg)) != 0)
               check($sformatf("row%0d_gapless%0d", r, i), 64'(beats[i].cyc - beats[i-1].cyc), 64'd1);
         end
      end

      // cfg_data raised mid-burst: current burst still ends at 4 words.
      do_reset();
      cfg_data = 16'd4;
      preload(18, 32'h5000);
      wait_beats("cfgchg_start", 1);
      cfg_data = 16'd16;
      run(30);
      check("cfgchg_beats1", 64'(beats.size()), 64'd4);
      if (beats.size() >= 4)
         check("cfgchg_last1", 64'(beats[3].last), 64'd1);
      check("cfgchg_sts1", 64'(sts_data), 64'd1);
      check("cfgchg_remain1", 64'(fifo_q.size()), 64'd14);
      preload(2, 32'h5012);
      run(40);
      check("cfgchg_beats2", 64'(beats.size()), 64'd20);
      if (beats.size() >= 20) begin
         check("cfgchg_first2", 64'(beats[4].data), 64'h5004);
         check("cfgchg_end2",   64'(beats[19].data), 64'h5013);
         check("cfgchg_last2",  64'(beats[19].last), 64'd1);
         check("cfgchg_nolast", 64'(beats[18].last), 64'd0);
      end
      check("cfgchg_sts2", 64'(sts_data), 64'd2);

      // Reset in the middle of a burst drops it without a tlast.
      do_reset();
      cfg_data = 16'd8;
      preload(8, 32'h6000);
      wait_beats("midrst_start", 2);
      areset = 1'b1;
      tick();
      areset = 1'b0;
      check("midrst_tvalid", 64'(m_if.tvalid), 64'd0);
      check("midrst_tlast",  64'(m_if.tlast),  64'd0);
      check("midrst_sts",    64'(sts_data),    64'd0);
      run(20);
      lasts = 0;
      foreach (beats[i]) if (beats[i].last) lasts++;
      check("midrst_no_tlast", 64'(lasts), 64'd0);
      check("midrst_sts_after", 64'(sts_data), 64'd0);

      // Partial FIFO below the burst length.
      do_reset();
      cfg_data = 16'd8;
      preload(3, 32'h7000);
`ifdef AXIS_BURST_TIMEOUT_EN
      run(40);
      check("timeout_beats", 64'(beats.size()), 64'd3);
      if (beats.size() >= 3) begin
         check("timeout_data2", 64'(beats[2].data), 64'h7002);
         check("timeout_last2", 64'(beats[2].last), 64'd1);
         check("timeout_last1", 64'(beats[1].last), 64'd0);
      end
      check("timeout_sts", 64'(sts_data), 64'd1);
`else
      run(1000);
      check("partial_beats",  64'(beats.size()),  64'd0);
      check("partial_sts",    64'(sts_data),      64'd0);
      check("partial_remain", 64'(fifo_q.size()), 64'd3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
